// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, no parity, one stop bit. Each bit is sampled once
// at its centre after a 2-flop synchronizer, and the result is reported as o_vld or o_err.
module uart_rx #(
   parameter int FREQ = 1_000_000,
   parameter int RATE = 115_200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_vld,
   output logic       o_err
);

   localparam int DIV   = FREQ / RATE;
   localparam int HALF  = DIV / 2;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       idx;
   logic [7:0]       shreg;
   logic             rx_meta;
   logic             rx_s;
   logic             rx_prev;
   logic             fall;

   // Synchronizer and edge flop reset to the idle-line level so that reset never looks like a start edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign fall = rx_prev & ~rx_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         idx    <= '0;
         o_data <= 8'h00;
         o_vld  <= 1'b0;
         o_err  <= 1'b0;
      end else begin
         o_vld <= 1'b0;
         o_err <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               idx <= '0;
               if (fall) state <= START;
            end
            START: begin
               if (cnt == CNT_HALF) begin
                  cnt   <= '0;
                  idx   <= '0;
                  state <= rx_s ? IDLE : DATA;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  idx <= idx + 3'd1;
                  if (idx == 3'd7) state <= STOP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (cnt == CNT_LAST) begin
                  // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge
                  cnt   <= '0;
                  state <= IDLE;
                  if (rx_s) begin
                     o_data <= shreg;
                     o_vld  <= 1'b1;
                  end else begin
                     o_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Shift register is pure data; a stale partial byte is never published without a full frame
   always_ff @(posedge clk) begin
      if (state == DATA && cnt == CNT_LAST) shreg[idx] <= rx_s;
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are described by byte value and stop level, and the
// expected pulse train is derived from frame start times and the bit-centre sampling rule.
module tb_uart_rx;

   localparam int FREQ = 1_000_000;
   localparam int RATE = 115_200;
   localparam int DIV  = FREQ / RATE;
   localparam int HALF = DIV / 2;
   // 2 sync flops + 1 edge detect, half a bit to the start centre, 9 more bit times to the stop centre
   localparam int LAT  = 3 + HALF + 9 * DIV;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_rx = 1'b1;
   logic [7:0] o_data;
   logic       o_vld;
   logic       o_err;

   uart_rx #(.FREQ(FREQ), .RATE(RATE)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_rx   (i_rx),
      .o_data (o_data),
      .o_vld  (o_vld),
      .o_err  (o_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int         tests = 0;
   int         fails = 0;
   int         vld_cnt = 0;
   int         err_cnt = 0;
   int         vld_t[$];
   logic [7:0] exp_vld[int];
   bit         exp_err[int];
   logic [7:0] mdl_data = 8'h00;

   always @(negedge clk) begin
      bit ev;
      bit ee;
      ev = exp_vld.exists(cyc);
      ee = exp_err.exists(cyc);
      if (ev) begin
         mdl_data = exp_vld[cyc];
         exp_vld.delete(cyc);
      end
      if (ee) exp_err.delete(cyc);
      if (!rst_n) mdl_data = 8'h00;
      tests++;
      if (o_vld !== ev || o_err !== ee || o_data !== mdl_data) begin
         fails++;
         $display("FAIL cycle_check @%0d: got vld=%b err=%b data=%h, expected vld=%b err=%b data=%h",
                  cyc, o_vld, o_err, o_data, ev, ee, mdl_data);
      end
      if (o_vld === 1'b1) begin
         vld_cnt++;
         vld_t.push_back(cyc);
      end
      if (o_err === 1'b1) err_cnt++;
   end

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
      end
   endtask

   task automatic bit_out(input logic b, input int n);
      i_rx = b;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      if (stop) exp_vld[cyc + LAT] = b;
      else      exp_err[cyc + LAT] = 1'b1;
      bit_out(1'b0, DIV);
      for (int i = 0; i < 8; i++) bit_out(b[i], DIV);
      bit_out(stop, DIV);
      i_rx = 1'b1;
   endtask

   // Transmitter stand-in for the loopback case: one strobe loads a 10-bit frame shifted out LSB first
   task automatic tx_send(input logic [7:0] b);
      logic [9:0] sh;
      sh = {1'b1, b, 1'b0};
      exp_vld[cyc + LAT] = b;
      for (int i = 0; i < 10; i++) begin
         i_rx = sh[0];
         for (int c = 0; c < DIV; c++) @(posedge clk);
         #1;
         sh = sh >> 1;
      end
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      check("reset_data", o_data, 8'h00);
      check("reset_vld", o_vld, 0);
      check("reset_err", o_err, 0);
      rst_n = 1'b1;
      bit_out(1'b1, 2 * DIV);

      // single frame
      send(8'h6A, 1'b1);
      bit_out(1'b1, 2 * DIV);
      check("frame_6A_vld_count", vld_cnt, 1);
      check("frame_6A_err_count", err_cnt, 0);
      check("frame_6A_data", o_data, 8'h6A);

      // false start: 2-cycle low glitch
      bit_out(1'b0, 2);
      bit_out(1'b1, 4 * DIV);
      check("false_start_vld_count", vld_cnt, 1);
      check("false_start_err_count", err_cnt, 0);
      send(8'hA5, 1'b1);
      bit_out(1'b1, 2 * DIV);
      check("after_false_start_data", o_data, 8'hA5);

      // framing error
      send(8'h3C, 1'b0);
      bit_out(1'b1, 2 * DIV);
      check("framing_err_count", err_cnt, 1);
      check("framing_vld_count", vld_cnt, 2);
      check("framing_data_kept", o_data, 8'hA5);

      // back-to-back frames
      n = vld_t.size();
      send(8'h00, 1'b1);
      send(8'hFF, 1'b1);
      bit_out(1'b1, 2 * DIV);
      check("b2b_vld_count", vld_cnt, 4);
      if (vld_t.size() >= n + 2) check("b2b_spacing", vld_t[n+1] - vld_t[n], 80);
      else check("b2b_pulses_seen", vld_t.size() - n, 2);
      check("b2b_last_data", o_data, 8'hFF);

      // break: line held low for many bit times
      exp_err[cyc + LAT] = 1'b1;
      bit_out(1'b0, 30 * DIV);
      bit_out(1'b1, 3 * DIV);
      check("break_err_count", err_cnt, 2);
      check("break_vld_count", vld_cnt, 4);

      // reset during bit 3 of a frame
      bit_out(1'b0, DIV);
      bit_out(1'b0, DIV);
      bit_out(1'b1, DIV);
      bit_out(1'b0, DIV);
      bit_out(1'b1, HALF);
      rst_n = 1'b0;
      i_rx  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("midreset_data", o_data, 8'h00);
      rst_n = 1'b1;
      bit_out(1'b1, 12 * DIV);
      check("midreset_vld_count", vld_cnt, 4);
      check("midreset_err_count", err_cnt, 2);
      check("midreset_data_after", o_data, 8'h00);
      send(8'h55, 1'b1);
      bit_out(1'b1, 2 * DIV);
      check("after_reset_data", o_data, 8'h55);

      // loopback from transmitter stand-in
      tx_send(8'h6A);
      bit_out(1'b1, 2 * DIV);
      check("loopback_data", o_data, 8'h6A);
      check("loopback_vld_count", vld_cnt, 6);

      check("pending_expectations", exp_vld.num() + exp_err.num(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
